hack_kbd_scheduler: RTL

//  Shares the Hack KBD memory-mapped register (0x6000) between two requesters.
//  - Physical keyboard: level-coded Hack scancode from the PS/2 mapper.
//  - Injected text: host autotype/paste stream, queued in a FIFO.

---
 rtl/hack_kbd_pkg.sv | 22 ++
 rtl/hack_kbd_fifo.sv | 76 +++++++
 rtl/hack_kbd_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared state encoding and named Hack keyboard scancodes for the KBD scheduler.
// Cursor and function keys follow the Hack platform's extended code map.
package hack_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PHYS     = 2'd1,
    ST_INJ_HOLD = 2'd2,
    ST_GAP      = 2'd3
  } kbd_state_t;

  localparam logic [7:0] KEY_ENTER = 8'd128;
  localparam logic [7:0] KEY_BKSP  = 8'd129;
  localparam logic [7:0] KEY_LEFT  = 8'd130;
  localparam logic [7:0] KEY_UP    = 8'd131;
  localparam logic [7:0] KEY_RIGHT = 8'd132;
  localparam logic [7:0] KEY_DOWN  = 8'd133;
  localparam logic [7:0] KEY_ESC   = 8'd140;
  localparam logic [7:0] KEY_F1    = 8'd141;
  localparam logic [7:0] KEY_F12   = 8'd152;

endpackage

// File: rtl/hack_kbd_fifo.sv
// Injected-scancode queue with flush; level/empty/full are registered, head is read combinationally.
// Push is refused while full (no bypass at full); zero codes are acknowledged but dropped.
module hack_kbd_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [DW-1:0]          push_dat,
  output logic                   push_rdy,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DW-1:0]          head_dat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          do_push, do_pop;

  assign push_rdy = (level_q != LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push_vld && push_rdy && (push_dat != '0) && !flush;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: only entries covered by level are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hack_kbd_scheduler.sv
// Arbitrates the Hack KBD register between the physical keyboard and a queued injected-text stream.
// Outputs registered (1-cycle latency); inj_ready drops only when the queue is full.
module hack_kbd_scheduler
  import hack_kbd_pkg::*;
#(
  parameter int HOLD_CYCLES = 500000,
  parameter int GAP_CYCLES  = 250000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  phys_code,
  input  logic                        inj_valid,
  input  logic [7:0]                  inj_code,
  output logic                        inj_ready,
  input  logic                        inj_flush,
  output logic [15:0]                 kbd_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  kbd_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    kbd_q, kbd_d;
  logic [7:0]    head_dat;
  logic          fifo_empty;
  logic          pop;

  hack_kbd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push_vld (inj_valid),
    .push_dat (inj_code),
    .push_rdy (inj_ready),
    .pop      (pop),
    .flush    (inj_flush),
    .head_dat (head_dat),
    .level    (fifo_level),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kbd_d   = kbd_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        kbd_d = '0;
        if (phys_code != '0) begin
          state_d = ST_PHYS;
          kbd_d   = phys_code;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_INJ_HOLD;
          kbd_d   = head_dat;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end
      end
      ST_PHYS: begin
        if (phys_code == '0) begin
          state_d = ST_GAP;
          kbd_d   = '0;
          cnt_d   = CW'(GAP_CYCLES - 1);
        end else begin
          kbd_d = phys_code;
        end
      end
      // Injected keys are never preempted so the program always sees the full hold.
      ST_INJ_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          kbd_d   = '0;
          cnt_d   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        kbd_d = '0;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        kbd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kbd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kbd_q   <= kbd_d;
    end
  end

  assign kbd_out = {8'h00, kbd_q};
  assign busy    = (state_q != ST_IDLE);

endmodule
